gp_serial_rx: RTL
=================

# gp_serial_rx

Single-lane asynchronous-frame serial receiver for GreenPAK4 designs. It samples a serial input `sdi` once per bit-period strobe and deframes start / data / optional parity / stop bits. Each accepted frame is presented as a parallel word with a one-cycle valid pulse. It is the receive end of the team's GP serial link; the bit strobe comes from an external GP_COUNT-based divider.

## Interface
Parameters:
- `WIDTH`, 8, data bits per frame (1..8), LSB first
- `PARITY_EN`, 1, 1 = parity bit follows the data bits; 0 = no parity bit
- `ODD_PARITY`, 0, 1 = odd parity expected, 0 = even (ignored when `PARITY_EN`=0)

Ports:
- `clk`  input  1  system clock; all state changes on its rising edge
- `clr`  input  1  asynchronous, active-low reset; low forces reset state immediately
- `sdi`  input  1  serial data in; idle level high; asynchronous to `clk`
- `sample_en`  input  1  bit strobe; one `clk`-wide pulse per bit period (may be held high = one bit per clock)
- `data`  output  WIDTH  last accepted word
- `valid`  output  1  one-cycle pulse: `data` just updated
- `parity_err`  output  1  parity status of last frame that reached STOP
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low
- `busy`  output  1  high while not in IDLE

## Operation
- Input conditioning: `sdi` passes a 2-flop synchronizer (`sdi_s`); both flops reset to 1 so reset never creates a false start.
- State machine, advancing only on cycles with `sample_en`=1:
  - IDLE: `sdi_s`=0 -> DATA, bit counter=0, shift reg=0, running parity=0. Otherwise stay.
  - DATA: shift `sdi_s` into MSB of the shift register (right shift, so first bit lands in bit 0 after WIDTH shifts); XOR into running parity; counter++. After the WIDTH-th bit -> PARITY if `PARITY_EN`, else STOP.
  - PARITY: XOR `sdi_s` into running parity -> STOP.
  - STOP: if `sdi_s`=1, `data`<=shift register, `valid` pulses, and `parity_err` <= (running parity != `ODD_PARITY`) when `PARITY_EN`, else 0. If `sdi_s`=0, `frame_err` pulses; `data`, `valid` and `parity_err` are unchanged. Either way -> IDLE.
- Parity sum covers the data bits plus the parity bit. A result of 0 means even parity; 1 means odd parity.
- A frame with a parity error is still delivered (`valid` pulses); `parity_err`=1 flags it. `parity_err` holds until the next frame reaches STOP.
- No flow control: `data` is overwritten by the next good frame whether or not it was consumed.
- Bit counter width: ceil(log2(WIDTH+1)); it never wraps within a frame.
- Break (line held low): the frame completes with a `frame_err` pulse. The FSM returns to IDLE and immediately sees `sdi_s`=0 at the next strobe, starting a new frame. This is required behaviour.

## Timing
- Reset values: `data`=0, `valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, FSM=IDLE, synchronizer=1.
- `clr` low mid-frame aborts the frame and applies reset values asynchronously. No `valid` or `frame_err` is emitted for the aborted frame.
- `sdi`-to-`sdi_s` latency: 2 `clk` cycles.
- `valid` / `frame_err` rise in the cycle after the STOP-state `sample_en` edge, and last exactly one cycle.
- `busy` rises the cycle after the start-bit strobe. It falls in the same cycle `valid` / `frame_err` rises.
- Frame length in strobes: 1 + WIDTH + `PARITY_EN` + 1. Back-to-back frames with no idle strobe between stop and the next start are accepted.
- `sample_en`=0 freezes the FSM and all outputs (the synchronizer keeps running). `valid` still drops after one cycle.

## Test plan
- Reset/idle: hold `clr`=0, then release with `sdi`=1 and `sample_en`=1 for 20 cycles -> all outputs stay 0, `busy`=0.
- Good frame, WIDTH=8, even parity: send 0xA5 (start, 1,0,1,0,0,1,0,1, parity 0, stop 1) with `sample_en` every 4 clocks -> one `valid` pulse, `data`=0xA5, `parity_err`=0, `frame_err` never high.
- Parity error: same frame with parity bit 1 -> `valid` pulses, `data`=0xA5, `parity_err`=1. A following good 0x3C frame -> `parity_err`=0.
- Framing error: send 0x5A with stop bit 0 -> `frame_err` pulses once, no `valid`, `data` keeps its previous value.
- Back-to-back at `sample_en`=1 constant: frames 0x01, then 0xFF with no idle bit -> two `valid` pulses 11 cycles apart, carrying 0x01 then 0xFF.
- Reset mid-frame: drop `clr` after the 4th data bit -> `busy`=0 asynchronously, no `valid`. After release, a good frame 0x7E is received correctly.

Source files
------------

// File: rtl/gp_serial_rx.sv
// Asynchronous-frame serial receiver: start / WIDTH data bits (LSB first) / optional parity / stop,
// advanced once per external bit strobe; each accepted word is presented with a one-cycle valid pulse.
module gp_serial_rx #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          ODD_PARITY = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sdi,
    input  logic             sample_en,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t           state, state_d;
    logic             sync1, sdi_s;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] shreg, shreg_d, data_d;
    logic             par, par_d;
    logic             valid_d, perr_d, ferr_d, busy_d;

    // Two-flop synchronizer; idle-high reset value keeps reset from looking like a start bit
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1 <= 1'b1;
            sdi_s <= 1'b1;
        end else begin
            sync1 <= sdi;
            sdi_s <= sync1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            shreg      <= shreg_d;
            par        <= par_d;
            data       <= data_d;
            valid      <= valid_d;
            parity_err <= perr_d;
            frame_err  <= ferr_d;
            busy       <= busy_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a strobe arrives
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        shreg_d = shreg;
        par_d   = par;
        data_d  = data;
        valid_d = 1'b0;
        perr_d  = parity_err;
        ferr_d  = 1'b0;

        if (sample_en) begin
            case (state)
                IDLE: begin
                    if (!sdi_s) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        shreg_d = '0;
                        par_d   = 1'b0;
                    end
                end
                DATA: begin
                    // Right shift with new bit at MSB: first bit received ends up in bit 0
                    shreg_d = WIDTH'({sdi_s, shreg} >> 1);
                    par_d   = par ^ sdi_s;
                    cnt_d   = cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        if (PARITY_EN) state_d = PARITY;
                        else           state_d = STOP;
                    end
                end
                PARITY: begin
                    par_d   = par ^ sdi_s;
                    state_d = STOP;
                end
                STOP: begin
                    if (sdi_s) begin
                        data_d  = shreg;
                        valid_d = 1'b1;
                        perr_d  = PARITY_EN && (par != ODD_PARITY);
                    end else begin
                        ferr_d  = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

endmodule
